// File: rtl/controller_ram_dp_if.sv
// Avalon-MM slave bundle for one port of the controller dual-port RAM.
interface controller_ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/controller_ram_dp.sv
// Dual-port controller RAM: two Avalon-MM slaves with byte enables,
// read latency 1 or 2 with readdatavalid, optional zero-fill after reset.
module controller_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0,
  parameter     INIT_FILE      = "controller_ram.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic                reset_req,
  output logic                init_done,
  controller_ram_dp_if.slave  s1,
  controller_ram_dp_if.slave  s2
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clear_addr, clear_addr_next;
  logic                    en;
  logic                    busy;
  logic                    clear_we;
  logic                    acc_wr1, acc_wr2;
  logic                    acc_rd [2];
  logic [ADDR_WIDTH-1:0]   rd_addr [2];
  logic                    vld   [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0]   rdata [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0]   mem   [DEPTH];

  assign en   = clken & ~reset_req;
  assign busy = reset | (state != READY) | ~en;

  assign s1.waitrequest = busy;
  assign s2.waitrequest = busy;

  // A simultaneous read+write on one port executes only the write.
  assign acc_rd[0]  = s1.chipselect & s1.read & ~s1.write & ~busy;
  assign acc_rd[1]  = s2.chipselect & s2.read & ~s2.write & ~busy;
  assign acc_wr1    = s1.chipselect & s1.write & ~busy;
  assign acc_wr2    = s2.chipselect & s2.write & ~busy;
  assign rd_addr[0] = s1.address;
  assign rd_addr[1] = s2.address;
  assign clear_we   = (state == CLEAR) & en & ~reset;

  // State register for the clear sequencer and init_done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clear_addr <= '0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_next;
      clear_addr <= clear_addr_next;
      init_done  <= (state_next == READY);
    end
  end

  // Clear walks every word once per enabled cycle, then hands over to READY.
  always_comb begin
    state_next      = state;
    clear_addr_next = clear_addr;
    if (state == CLEAR && en) begin
      clear_addr_next = clear_addr + 1'b1;
      if (clear_addr == '1) begin
        state_next = READY;
      end
    end
  end

  // Memory array writes; s2 lanes are applied first so s1 wins overlapping lanes.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end
    for (int unsigned i = 0; i < NB; i++) begin
      if (acc_wr2 && s2.byteenable[i]) begin
        mem[s2.address][i*8 +: 8] <= s2.writedata[i*8 +: 8];
      end
      if (acc_wr1 && s1.byteenable[i]) begin
        mem[s1.address][i*8 +: 8] <= s1.writedata[i*8 +: 8];
      end
    end
  end

  // Per-port read pipeline; captures pre-write data and freezes while en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned s = 0; s < READ_LATENCY; s++) begin
          vld[p][s]   <= 1'b0;
          rdata[p][s] <= '0;
        end
      end
    end else if (en) begin
      for (int unsigned p = 0; p < 2; p++) begin
        vld[p][0] <= acc_rd[p];
        if (acc_rd[p]) begin
          rdata[p][0] <= mem[rd_addr[p]];
        end
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
          vld[p][s] <= vld[p][s-1];
          if (vld[p][s-1]) begin
            rdata[p][s] <= rdata[p][s-1];
          end
        end
      end
    end
  end

  assign s1.readdatavalid = vld[0][READ_LATENCY-1] & en;
  assign s2.readdatavalid = vld[1][READ_LATENCY-1] & en;
  assign s1.readdata      = rdata[0][READ_LATENCY-1];
  assign s2.readdata      = rdata[1][READ_LATENCY-1];

endmodule

// File: tb/tb_controller_ram_dp.sv
// Randomised + directed bench for controller_ram_dp. Two instances share the
// stimulus: A = latency 1 with zero-fill, B = latency 2 keeping contents.
module tb_controller_ram_dp;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wd;
  } cmd_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic [3:0]  kn;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clken, reset_req;
  logic done_a, done_b;
  cmd_t cmd1, cmd2;

  controller_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  controller_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
  controller_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
  controller_ram_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

  assign {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata} = cmd1;
  assign {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata} = cmd2;
  assign {b1.chipselect, b1.read, b1.write, b1.address, b1.byteenable, b1.writedata} = cmd1;
  assign {b2.chipselect, b2.read, b2.write, b2.address, b2.byteenable, b2.writedata} = cmd2;

  controller_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
    .INIT_FILE("controller_ram.hex")
  ) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .init_done(done_a), .s1(a1.slave), .s2(a2.slave)
  );

  controller_ram_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(0),
    .INIT_FILE("controller_ram.hex")
  ) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .init_done(done_b), .s1(b1.slave), .s2(b2.slave)
  );

  // observed outputs indexed [dut][port]
  logic        wq [2][2];
  logic        rv [2][2];
  logic [31:0] ro [2][2];
  logic        dn [2];
  assign wq[0][0] = a1.waitrequest;   assign wq[0][1] = a2.waitrequest;
  assign wq[1][0] = b1.waitrequest;   assign wq[1][1] = b2.waitrequest;
  assign rv[0][0] = a1.readdatavalid; assign rv[0][1] = a2.readdatavalid;
  assign rv[1][0] = b1.readdatavalid; assign rv[1][1] = b2.readdatavalid;
  assign ro[0][0] = a1.readdata;      assign ro[0][1] = a2.readdata;
  assign ro[1][0] = b1.readdata;      assign ro[1][1] = b2.readdata;
  assign dn[0] = done_a;
  assign dn[1] = done_b;

  // behavioural model state
  logic [31:0] mem [2][DEPTH];
  logic [3:0]  kn  [2][DEPTH];
  int          clear_left [2];
  logic        init_q [2];
  int unsigned ecnt [2];
  pend_t       pq [2][2][$];
  logic [31:0] last_rd [2][2];
  int unsigned npulse [2][2];
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  bit          checking = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic cmp(input string name, input int d, input int p,
                     input logic [31:0] act, input logic [31:0] exp, input logic [31:0] mask);
    n_vec++;
    if (((act ^ exp) & mask) != 0) begin
      n_fail++;
      $display("FAIL %s dut%0d port%0d t=%0t: got %h, expected %h", name, d, p + 1, $time, act, exp);
    end
  endtask

  task automatic check_out(input int d, input logic r, input logic ce, input logic rq);
    logic en, ew, ev;
    en = ce & ~rq;
    ew = r | (clear_left[d] != 0) | ~en;
    cmp("init_done", d, 0, 32'(dn[d]), 32'(init_q[d]), 32'h1);
    for (int p = 0; p < 2; p++) begin
      cmp("waitrequest", d, p, 32'(wq[d][p]), 32'(ew), 32'h1);
      ev = en && pq[d][p].size() > 0 && pq[d][p][0].due == ecnt[d];
      cmp("readdatavalid", d, p, 32'(rv[d][p]), 32'(ev), 32'h1);
      if (ev) cmp("readdata", d, p, ro[d][p], pq[d][p][0].data, lanes(pq[d][p][0].kn));
      if (rv[d][p]) begin
        npulse[d][p]++;
        last_rd[d][p] = ro[d][p];
      end
    end
  endtask

  task automatic step(input int d, input logic r, input logic ce, input logic rq,
                      input cmd_t c1, input cmd_t c2);
    cmd_t  c [2];
    pend_t e;
    logic  en;
    c[0] = c1;
    c[1] = c2;
    en = ce & ~rq;
    if (r) begin
      pq[d][0].delete();
      pq[d][1].delete();
      clear_left[d] = (d == 0) ? DEPTH : 0;
      init_q[d] = 1'b0;
      return;
    end
    if (en) begin
      for (int p = 0; p < 2; p++)
        if (pq[d][p].size() > 0 && pq[d][p][0].due == ecnt[d]) void'(pq[d][p].pop_front());
      if (clear_left[d] != 0) begin
        clear_left[d]--;
        if (clear_left[d] == 0)
          for (int a = 0; a < DEPTH; a++) begin
            mem[d][a] = '0;
            kn[d][a]  = 4'hF;
          end
      end else begin
        for (int p = 0; p < 2; p++)
          if (c[p].cs && c[p].rd && !c[p].wr) begin
            e.due  = ecnt[d] + lat(d);
            e.data = mem[d][c[p].addr];
            e.kn   = kn[d][c[p].addr];
            pq[d][p].push_back(e);
          end
        // port 2 first, port 1 overrides overlapping lanes
        for (int p = 1; p >= 0; p--)
          if (c[p].cs && c[p].wr)
            for (int i = 0; i < 4; i++)
              if (c[p].be[i]) begin
                mem[d][c[p].addr][i*8 +: 8] = c[p].wd[i*8 +: 8];
                kn[d][c[p].addr][i] = 1'b1;
              end
      end
      ecnt[d]++;
    end
    init_q[d] = (clear_left[d] == 0);
  endtask

  task automatic cyc(input logic r, input logic ce, input logic rq, input cmd_t c1, input cmd_t c2);
    reset = r; clken = ce; reset_req = rq;
    cmd1 = c1; cmd2 = c2;
    #2;
    if (checking) for (int d = 0; d < 2; d++) check_out(d, r, ce, rq);
    for (int d = 0; d < 2; d++) step(d, r, ce, rq, c1, c2);
    @(negedge clk);
  endtask

  function automatic cmd_t idle();
    return '0;
  endfunction

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    cmd_t c = '0;
    c.cs = 1'b1; c.wr = 1'b1; c.addr = a; c.be = be; c.wd = d;
    return c;
  endfunction

  function automatic cmd_t rd(input logic [AW-1:0] a);
    cmd_t c = '0;
    c.cs = 1'b1; c.rd = 1'b1; c.addr = a;
    return c;
  endfunction

  function automatic cmd_t rcmd();
    cmd_t c;
    c.cs   = ($urandom_range(0, 3) != 0);
    c.rd   = 1'($urandom_range(0, 1));
    c.wr   = ($urandom_range(0, 2) == 0);
    c.addr = AW'($urandom_range(0, DEPTH - 1));
    c.be   = 4'($urandom_range(0, 15));
    c.wd   = $urandom;
    return c;
  endfunction

  task automatic go(input cmd_t c1, input cmd_t c2);
    cyc(1'b0, 1'b1, 1'b0, c1, c2);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) go(idle(), idle());
  endtask

  task automatic clear_timing(input string name);
    int first_hi;
    first_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      if (first_hi == 0 && done_a) first_hi = i;
      go(idle(), idle());
    end
    cmp(name, 0, 0, 32'(first_hi), 32'd17, '1);
  endtask

  initial begin
    int unsigned p0 [2];
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0; init_q[d] = 1'b0; clear_left[d] = 0;
      for (int a = 0; a < DEPTH; a++) begin mem[d][a] = '0; kn[d][a] = '0; end
      for (int p = 0; p < 2; p++) begin last_rd[d][p] = '0; npulse[d][p] = 0; end
    end
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b0, idle(), idle());
    checking = 1;
    cyc(1'b1, 1'b1, 1'b0, idle(), idle());
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) cmp("reset_readdata", d, p, ro[d][p], 32'h0, '1);

    // zero-fill takes 16 enabled cycles; reads afterwards return zero
    clear_timing("clear_done_cycle");
    go(rd(0), rd(9));
    idles(3);
    cmp("cleared_word", 0, 0, last_rd[0][0], 32'h0, '1);
    cmp("cleared_word", 0, 1, last_rd[0][1], 32'h0, '1);

    // byte-lane merge
    go(wr(3, 4'hF, 32'hDEADBEEF), idle());
    go(wr(3, 4'h1, 32'h00000055), idle());
    go(rd(3), idle());
    idles(3);
    cmp("lane_merge", 0, 0, last_rd[0][0], 32'hDEADBE55, '1);
    cmp("lane_merge", 1, 0, last_rd[1][0], 32'hDEADBE55, '1);

    // both ports write one word in the same cycle
    go(wr(5, 4'hF, 32'h0), idle());
    go(wr(5, 4'hF, 32'h11111111), wr(5, 4'hC, 32'h22222222));
    go(rd(5), idle());
    idles(3);
    cmp("dual_write_full", 0, 0, last_rd[0][0], 32'h11111111, '1);
    cmp("dual_write_full", 1, 0, last_rd[1][0], 32'h11111111, '1);
    go(wr(5, 4'hF, 32'h0), idle());
    go(wr(5, 4'h3, 32'h11111111), wr(5, 4'hC, 32'h22222222));
    go(rd(5), idle());
    idles(3);
    cmp("dual_write_split", 0, 0, last_rd[0][0], 32'h22221111, '1);
    cmp("dual_write_split", 1, 0, last_rd[1][0], 32'h22221111, '1);

    // cross-port read during write returns old data
    go(wr(7, 4'hF, 32'hA5A5A5A5), idle());
    go(wr(7, 4'hF, 32'h12345678), rd(7));
    idles(3);
    cmp("read_old", 0, 1, last_rd[0][1], 32'hA5A5A5A5, '1);
    cmp("read_old", 1, 1, last_rd[1][1], 32'hA5A5A5A5, '1);
    go(idle(), rd(7));
    idles(3);
    cmp("read_new", 0, 1, last_rd[0][1], 32'h12345678, '1);
    cmp("read_new", 1, 1, last_rd[1][1], 32'h12345678, '1);

    // clock-enable stall across back-to-back reads
    for (int d = 0; d < 2; d++) p0[d] = npulse[d][0];
    go(rd(3), idle());
    go(rd(5), idle());
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, idle(), idle());
    idles(4);
    for (int d = 0; d < 2; d++) cmp("stall_pulses", d, 0, npulse[d][0] - p0[d], 32'd2, '1);
    cmp("stall_last", 1, 0, last_rd[1][0], 32'h22221111, '1);

    // reset in the middle of a clear; retained contents without zero-fill
    go(wr(9, 4'hF, 32'hCAFEF00D), idle());
    cyc(1'b1, 1'b1, 1'b0, idle(), idle());
    idles(8);
    cyc(1'b1, 1'b1, 1'b0, idle(), idle());
    clear_timing("reclear_done_cycle");
    go(rd(9), idle());
    idles(3);
    cmp("survive_reset", 1, 0, last_rd[1][0], 32'hCAFEF00D, '1);
    cmp("cleared_after_reset", 0, 0, last_rd[0][0], 32'h0, '1);

    // random traffic with occasional reset, clken and reset_req gaps
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 15) == 0), rcmd(), rcmd());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
